// File: rtl/spi_slave.sv
// Receive-only SPI slave (mode 0, MSB first, no chip select) that frames words by bit count.
// Optional word counter output is enabled by defining SPI_SLAVE_WORD_COUNT_EN.
module spi_slave #(
  parameter int WORD_BITS = 32
) (
  input  logic                 spi_clk,
  input  logic                 reset,
  input  logic                 spi_mosi,
  output logic [WORD_BITS-1:0] data,
`ifdef SPI_SLAVE_WORD_COUNT_EN
  output logic [15:0]          word_count,
`endif
  output logic                 pixel_clock
);

  localparam int CNT_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);

  logic [WORD_BITS-1:0] shift_r;
  logic [CNT_W-1:0]     bit_cnt_r;
  logic [WORD_BITS-1:0] data_r;
  logic                 pixel_clock_r;

  logic [WORD_BITS-1:0] shift_next_s;
  logic                 last_bit_s;
  logic [WORD_BITS-1:0] shift_d_s;
  logic [CNT_W-1:0]     bit_cnt_d_s;
  logic [WORD_BITS-1:0] data_d_s;
  logic                 pixel_clock_d_s;

  // Next-state decode: the completing edge captures the full word and restarts framing.
  always_comb begin
    shift_next_s    = {shift_r[WORD_BITS-2:0], spi_mosi};
    last_bit_s      = (bit_cnt_r == LAST_BIT);
    shift_d_s       = shift_next_s;
    bit_cnt_d_s     = bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    data_d_s        = data_r;
    pixel_clock_d_s = 1'b0;
    if (last_bit_s) begin
      shift_d_s       = {WORD_BITS{1'b0}};
      bit_cnt_d_s     = {CNT_W{1'b0}};
      data_d_s        = shift_next_s;
      pixel_clock_d_s = 1'b1;
    end else begin
      pixel_clock_d_s = 1'b0;
    end
  end

  // Deserialiser, output word and strobe registers.
  always_ff @(posedge spi_clk or posedge reset) begin
    if (reset) begin
      shift_r       <= {WORD_BITS{1'b0}};
      bit_cnt_r     <= {CNT_W{1'b0}};
      data_r        <= {WORD_BITS{1'b0}};
      pixel_clock_r <= 1'b0;
    end else begin
      shift_r       <= shift_d_s;
      bit_cnt_r     <= bit_cnt_d_s;
      data_r        <= data_d_s;
      pixel_clock_r <= pixel_clock_d_s;
    end
  end

  assign data        = data_r;
  assign pixel_clock = pixel_clock_r;

`ifdef SPI_SLAVE_WORD_COUNT_EN
  logic [15:0] word_count_r;

  // Completed-word counter; wraps naturally at 16 bits.
  always_ff @(posedge spi_clk or posedge reset) begin
    if (reset) begin
      word_count_r <= 16'h0000;
    end else if (last_bit_s) begin
      word_count_r <= word_count_r + 16'h0001;
    end else begin
      word_count_r <= word_count_r;
    end
  end

  assign word_count = word_count_r;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: stimulus queues expected words, a negedge monitor checks them.
module tb_spi_slave;

  localparam int WB = 32;

  logic          spi_clk  = 1'b0;
  logic          reset    = 1'b1;
  logic          spi_mosi = 1'b0;
  logic [WB-1:0] data;
  logic          pixel_clock;
`ifdef SPI_SLAVE_WORD_COUNT_EN
  logic [15:0]   word_count;
  logic [15:0]   exp_wc = 16'h0000;
`endif

  int checks = 0;
  int errors = 0;
  logic [WB-1:0] exp_q[$];
  logic [WB-1:0] exp_data = '0;
  logic          prev_pix = 1'b0;

  spi_slave #(.WORD_BITS(WB)) dut (
    .spi_clk    (spi_clk),
    .reset      (reset),
    .spi_mosi   (spi_mosi),
    .data       (data),
`ifdef SPI_SLAVE_WORD_COUNT_EN
    .word_count (word_count),
`endif
    .pixel_clock(pixel_clock)
  );

  always #5 spi_clk = ~spi_clk;

  // Tasks are entered just after a falling edge; each bit is driven while the clock is low.
  task automatic send_word(input logic [WB-1:0] w);
    for (int i = WB - 1; i >= 0; i--) begin
      spi_mosi = w[i];
      if (i == 0) exp_q.push_back(w);
      @(negedge spi_clk); #1;
    end
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = 1'($urandom_range(1, 0));
      @(negedge spi_clk); #1;
    end
  endtask

  task automatic pulse_reset(input int n);
    reset = 1'b1;
    exp_q.delete();
    repeat (n) begin @(negedge spi_clk); #1; end
    reset = 1'b0;
  endtask

  // Monitor: sampled on the falling edge, away from the active rising edge.
  always @(negedge spi_clk) begin
    if (reset) begin
      checks++;
      if (data !== '0 || pixel_clock !== 1'b0)
        $display("FAIL reset_state: data=%h pixel_clock=%b, required data=0 pixel_clock=0", data, pixel_clock);
      if (data !== '0 || pixel_clock !== 1'b0) errors++;
      exp_data = '0;
      prev_pix = 1'b0;
`ifdef SPI_SLAVE_WORD_COUNT_EN
      exp_wc = 16'h0000;
      checks++;
      if (word_count !== 16'h0000) begin
        errors++;
        $display("FAIL reset_word_count: got %h required 0000", word_count);
      end
`endif
    end else begin
      if (pixel_clock === 1'b1) begin
        checks++;
        if (prev_pix) begin
          errors++;
          $display("FAIL pixel_consecutive: pixel_clock=1 two periods in a row, required single-period strobe");
        end
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: pixel_clock=1 with no word pending, required 0");
        end else begin
          exp_data = exp_q.pop_front();
`ifdef SPI_SLAVE_WORD_COUNT_EN
          exp_wc = exp_wc + 16'h0001;
`endif
        end
      end
      checks++;
      if (data !== exp_data) begin
        errors++;
        $display("FAIL data: got %h required %h (pixel_clock=%b)", data, exp_data, pixel_clock);
      end
`ifdef SPI_SLAVE_WORD_COUNT_EN
      checks++;
      if (word_count !== exp_wc) begin
        errors++;
        $display("FAIL word_count: got %h required %h", word_count, exp_wc);
      end
`endif
      prev_pix = pixel_clock;
    end
  end

  initial begin
    repeat (3) begin @(negedge spi_clk); #1; end
    reset = 1'b0;
    // Contiguous words: 0x12345678, then back-to-back 0xDEADBEEF / 0x0000FFFF.
    send_word(32'h12345678);
    send_word(32'hDEADBEEF);
    send_word(32'h0000FFFF);
    // Partial word lost across a reset.
    send_bits(13);
    pulse_reset(2);
    send_word(32'hA5A5A5A5);
    send_word(32'h80000001);
    send_word(32'hFFFFFFFF);
    spi_mosi = 1'b0;
    // Drain: allow a bounded number of cycles for the last strobe.
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge spi_clk);
    @(negedge spi_clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d words never strobed, required 0", exp_q.size());
    end
    checks++;
    if (pixel_clock !== 1'b0) begin
      errors++;
      $display("FAIL pixel_idle: got %b required 0", pixel_clock);
    end
    checks++;
    if (data !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL final_data: got %h required ffffffff", data);
    end
`ifdef SPI_SLAVE_WORD_COUNT_EN
    checks++;
    if (word_count !== 16'd3) begin
      errors++;
      $display("FAIL final_word_count: got %0d required 3", word_count);
    end
    pulse_reset(2);
    @(negedge spi_clk); #1;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
